// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational Imem and
// buffers words with their PC in a small FIFO toward decode.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT = 32'd40,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_done
);

   localparam int PW = $clog2(DEPTH);

   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [31:0]   PC_STEP  = 32'd4;
   localparam logic [31:0]   PC_RST   = {RESET_PC[31:2], 2'b00};

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } entry_t;

   entry_t          fifo_q [DEPTH];
   entry_t          fifo_d [DEPTH];
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            push, pop;
   logic            unused_redirect_lsb;

   // Redirect targets are forced to word alignment.
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign imem_addr   = fetch_pc_q;
   assign fetch_done  = (fetch_pc_q >= PC_LIMIT);
   assign instr_valid = (count_q != '0);
   assign instr       = fifo_q[rd_ptr_q].word;
   assign instr_pc    = fifo_q[rd_ptr_q].pc;

   assign pop  = instr_valid & instr_ready & ~redirect_valid;
   assign push = ~fetch_done & ~redirect_valid &
                 ((count_q < CNT_FULL) | pop);

   always_comb begin
      fifo_d     = fifo_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = '{word: imem_rdata, pc: fetch_pc_q};
            fetch_pc_d       = fetch_pc_q + PC_STEP;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= PC_RST;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= fifo_d[i];
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch, stall, redirect
// and reset scenarios against a queue of expected (pc, word) pairs.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_done;

   logic [63:0] exp_q [$];
   int          nvec;
   int          nerr;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_done     (fetch_done)
   );

   assign imem_rdata = 32'hA000_0000 | imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: each accepted head must match the oldest expected pair.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
         nvec++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_pop: pc=%h instr=%h, none expected",
                     instr_pc, instr);
         end else begin
            e = exp_q.pop_front();
            if (instr !== e[63:32] || instr_pc !== e[31:0]) begin
               nerr++;
               $display("FAIL stream: got pc=%h instr=%h, expected pc=%h instr=%h",
                        instr_pc, instr, e[31:0], e[63:32]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_range(input logic [31:0] lo, input logic [31:0] hi);
      for (logic [31:0] p = lo; p <= hi; p += 32'd4) begin
         exp_q.push_back({32'hA000_0000 | p, p});
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL %s_timeout: %0d words left, 0 required",
                  name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      nvec           = 0;
      nerr           = 0;
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // 1: reset state, then full stream 0..36
      step(3);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_done", {31'd0, fetch_done}, 32'd0);
      exp_range(32'd0, 32'd36);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      step(1);
      chk("first_valid", {31'd0, instr_valid}, 32'd1);
      chk("first_pc", instr_pc, 32'd0);
      wait_drain("t1");
      chk("t1_done", {31'd0, fetch_done}, 32'd1);
      chk("t1_addr", imem_addr, 32'd40);
      chk("t1_empty", {31'd0, instr_valid}, 32'd0);

      // 2: stall until full
      instr_ready = 1'b0;
      do_redirect(32'd0);
      step(8);
      chk("full_addr", imem_addr, 32'd16);
      chk("full_instr", instr, 32'hA000_0000);
      chk("full_pc", instr_pc, 32'd0);
      chk("full_valid", {31'd0, instr_valid}, 32'd1);

      // 3: single pop on full FIFO pushes in the same edge
      exp_range(32'd0, 32'd0);
      instr_ready = 1'b1;
      step(1);
      instr_ready = 1'b0;
      chk("popfull_addr", imem_addr, 32'd20);
      chk("popfull_pc", instr_pc, 32'd4);
      step(2);
      chk("still_full_addr", imem_addr, 32'd20);
      exp_range(32'd4, 32'd36);
      instr_ready = 1'b1;
      wait_drain("t2");

      // 4: redirect with 3 buffered words and ready high
      instr_ready = 1'b0;
      do_redirect(32'd0);
      step(3);
      chk("t4_addr", imem_addr, 32'd12);
      instr_ready = 1'b1;
      do_redirect(32'h0000_0013);
      instr_ready = 1'b0;
      chk("redir_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h10);
      step(1);
      chk("redir_valid2", {31'd0, instr_valid}, 32'd1);
      chk("redir_pc", instr_pc, 32'h10);
      chk("redir_instr", instr, 32'hA000_0010);
      exp_range(32'h10, 32'd36);
      instr_ready = 1'b1;
      wait_drain("t4");

      // 5: redirect clears fetch_done
      chk("t5_done_pre", {31'd0, fetch_done}, 32'd1);
      instr_ready = 1'b0;
      do_redirect(32'd8);
      chk("t5_done", {31'd0, fetch_done}, 32'd0);
      chk("t5_addr", imem_addr, 32'd8);
      exp_range(32'd8, 32'd36);
      instr_ready = 1'b1;
      wait_drain("t5");
      chk("t5_done_post", {31'd0, fetch_done}, 32'd1);

      // 6: asynchronous reset mid-stream
      instr_ready = 1'b0;
      do_redirect(32'd0);
      step(2);
      chk("t6_valid_pre", {31'd0, instr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_valid", {31'd0, instr_valid}, 32'd0);
      chk("t6_addr", imem_addr, 32'd0);
      step(1);
      exp_range(32'd0, 32'd36);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      wait_drain("t6");
      chk("t6_end_valid", {31'd0, instr_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
